// File: rtl/regfile_writer_if.sv
// Write-port bundle for regfile_writer: valid/ready handshake with address and data.
// The master drives a request and the slave (the register file) returns ready.
interface regfile_writer_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          valid;
  logic          ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/regfile_writer.sv
// regfile_writer: 16 x 16-bit architectural register file.
// - Owns every write to register state.
// - Drives the flattened 256-bit register bus consumed by the downstream flag generators.
// - Provides one handshaked write port, two registered read ports with write-through
//   bypass, and a sequenced bulk-clear engine that zeroes one register per cycle.
// Optional feature macro: REGFILE_R0_ZERO_EN -- r0 hardwired to zero; writes to
// address 0 are accepted but discarded.
module regfile_writer #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_writer_if.slave        wr,
  input  logic [$clog2(NREGS)-1:0] rd_addr_a,
  output logic [WIDTH-1:0]       rd_data_a,
  input  logic [$clog2(NREGS)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]       rd_data_b,
  input  logic                   clr_req,
  output logic                   busy,
  output logic [NREGS*WIDTH-1:0] registers
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0] regs [NREGS];
  logic            wr_fire;
  logic            wr_en;

  assign busy     = (state == CLEAR);
  assign wr.ready = ~busy;
  assign wr_fire  = wr.valid & wr.ready;

`ifdef REGFILE_R0_ZERO_EN
  // r0 is hardwired: the handshake completes but the data never reaches state or bypass.
  assign wr_en = wr_fire & (wr.addr != '0);
`else
  assign wr_en = wr_fire;
`endif

  // Clear FSM state and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: a clear request starts a sweep from r0; the sweep ends after the last
  // register, and the counter wraps back to zero on its own.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Register state: the clear sweep has priority; writes are blocked by ready while clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (busy) begin
      regs[cnt] <= '0;
    end else if (wr_en) begin
      regs[wr.addr] <= wr.data;
    end
  end

  // Registered read ports with write-through bypass for a same-edge write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= (wr_en && (wr.addr == rd_addr_a)) ? wr.data : regs[rd_addr_a];
      rd_data_b <= (wr_en && (wr.addr == rd_addr_b)) ? wr.data : regs[rd_addr_b];
    end
  end

  // Flatten the register array onto the downstream bus, reg i at bits [16i+15:16i].
  always_comb begin
    registers = '0;
    for (int i = 0; i < NREGS; i++) registers[i*WIDTH +: WIDTH] = regs[i];
  end

endmodule
